// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronised RX, mid-bit sampling, LSB-first data, sticky rdy.
// Optional parity stage is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 receiving
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  // Parity error: combined XOR of data and parity bit must equal the configured sense.
  function automatic logic calc_par_err(input logic [DATA_BITS-1:0] data, input logic par_bit);
    return ((^data) ^ par_bit) != PARITY_ODD;
  endfunction

  state_t                 state_r, state_nxt_s;
  logic                   sync1_r, rx_sync_r;
  logic [CW-1:0]          cnt_r, load_val_s;
  logic [BW-1:0]          bit_cnt_r;
  logic [DATA_BITS-1:0]   shift_r, rx_data_r;
  logic                   rdy_r, frm_err_r, par_err_r, receiving_r;
  logic                   expire_s, load_s, bit_clr_s, shift_en_s, done_s, start_det_s;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_r, par_en_s;
`endif

  assign expire_s  = (cnt_r == {CW{1'b0}});
  assign rx_data   = rx_data_r;
  assign rdy       = rdy_r;
  assign frm_err   = frm_err_r;
  assign par_err   = par_err_r;
  assign receiving = receiving_r;

  // Two-flop synchroniser; flops preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      sync1_r   <= RX;
      rx_sync_r <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    load_val_s  = FULL_LOAD;
    bit_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    done_s      = 1'b0;
    start_det_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!rx_sync_r) begin
          state_nxt_s = START;
          load_s      = 1'b1;
          load_val_s  = HALF_LOAD;
          bit_clr_s   = 1'b1;
          start_det_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (expire_s) begin
          if (rx_sync_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DATA;
            load_s      = 1'b1;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (expire_s) begin
          shift_en_s = 1'b1;
          load_s     = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (expire_s) begin
          par_en_s    = 1'b1;
          load_s      = 1'b1;
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (expire_s) begin
          done_s = 1'b1;
          if (rx_sync_r) state_nxt_s = IDLE;
          else           state_nxt_s = WAIT_HI;
        end else begin
          state_nxt_s = STOP;
        end
      end
      WAIT_HI: begin
        if (rx_sync_r) state_nxt_s = IDLE;
        else           state_nxt_s = WAIT_HI;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Baud counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
    end else begin
      if (load_s) cnt_r <= load_val_s;
      else        cnt_r <= cnt_r - CW'(1);
      if (bit_clr_s)       bit_cnt_r <= {BW{1'b0}};
      else if (shift_en_s) bit_cnt_r <= bit_cnt_r + BW'(1);
      else                 bit_cnt_r <= bit_cnt_r;
      if (shift_en_s) shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
      else            shift_r <= shift_r;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit of the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        par_bit_r <= 1'b0;
    else if (par_en_s) par_bit_r <= rx_sync_r;
    else               par_bit_r <= par_bit_r;
  end
`endif

  // Frame results and handshake; a completion outranks a same-cycle clear of rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= {DATA_BITS{1'b0}};
      rdy_r       <= 1'b0;
      frm_err_r   <= 1'b0;
      par_err_r   <= 1'b0;
      receiving_r <= 1'b0;
    end else begin
      if (done_s) begin
        rx_data_r <= shift_r;
        frm_err_r <= ~rx_sync_r;
`ifdef UART_RX_PARITY_EN
        par_err_r <= calc_par_err(shift_r, par_bit_r);
`else
        par_err_r <= 1'b0;
`endif
      end else begin
        rx_data_r <= rx_data_r;
        frm_err_r <= frm_err_r;
        par_err_r <= par_err_r;
      end
      if (done_s)                      rdy_r <= 1'b1;
      else if (clr_rdy || start_det_s) rdy_r <= 1'b0;
      else                             rdy_r <= rdy_r;
      receiving_r <= (state_nxt_s != IDLE) && (state_nxt_s != WAIT_HI);
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (BAUD_DIV=16, DATA_BITS=8) with a frame scoreboard.
module tb_uart_rx_param;

  localparam int BD = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT    = 2 + BD / 2 + (DB + P + 1) * BD;
  localparam int NSTEPS = BD * (DB + 2 + P);

  typedef struct {
    logic [7:0] d;
    logic       frm;
    logic       par;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, RX, clr_rdy;
  logic [7:0] rx_data;
  logic       rdy, frm_err, par_err, receiving;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];

  uart_rx_param #(.DATA_BITS(DB), .BAUD_DIV(BD), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .par_err(par_err),
    .receiving(receiving)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame, one call per bit-cycle step; optional clear/probe/reset at given steps.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                            input int clr_k, input int chk_k, input logic chk_val, input int rst_k);
    int   e0;
    logic pb;
    exp_t e;
    e0 = cyc + 1;
    pb = (^d) ^ bad_par;
    if (rst_k < 0) begin
      e.d   = d;
      e.frm = ~stop_bit;
      e.par = (P == 1) ? bad_par : 1'b0;
      e.cyc = e0 + LAT;
      sb.push_back(e);
    end
    for (int k = 0; k < NSTEPS; k++) begin
      int b;
      b = k / BD;
      if (b == 0)                   RX = 1'b0;
      else if (b <= DB)             RX = d[b-1];
      else if (P == 1 && b == DB+1) RX = pb;
      else                          RX = stop_bit;
      clr_rdy = (k == clr_k);
      if (k == chk_k) check("rdy_probe", rdy, chk_val);
      if (k == rst_k) begin
        check("recv_before_rst", receiving, 1);
        rst_n = 1'b0;
        RX    = 1'b1;
        #1;
        check("rst_rx_data", rx_data, 0);
        check("rst_rdy", rdy, 0);
        check("rst_frm_err", frm_err, 0);
        check("rst_par_err", par_err, 0);
        check("rst_receiving", receiving, 0);
        step();
        rst_n = 1'b1;
        break;
      end
      step();
    end
    clr_rdy = 1'b0;
  endtask

  initial begin
    int cnt;
    exp_t e;
    logic rdy_q;
    rst_n   = 1'b0;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    rdy_q   = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rdy === 1'b1 && rdy_q !== 1'b1) begin
          check("sb_has_entry", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_rx_data", rx_data, e.d);
            check("sb_frm_err", frm_err, e.frm);
            check("sb_par_err", par_err, e.par);
            check("sb_rdy_cycle", cyc, e.cyc);
          end
        end
        rdy_q = rdy;
      end
    join_none

    repeat (3) step();
    check("reset_rx_data", rx_data, 0);
    check("reset_rdy", rdy, 0);
    check("reset_frm_err", frm_err, 0);
    check("reset_par_err", par_err, 0);
    check("reset_receiving", receiving, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Basic frame, then acknowledge leaves the data intact.
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 1'b0, -1);
    check("a5_rdy", rdy, 1);
    check("a5_data", rx_data, 8'hA5);
    clr_rdy = 1'b1;
    step();
    clr_rdy = 1'b0;
    check("clr_rdy_drops", rdy, 0);
    check("clr_keeps_data", rx_data, 8'hA5);

    // Glitch shorter than half a bit is rejected.
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      RX = (i < 4) ? 1'b0 : 1'b1;
      if (receiving === 1'b1) cnt++;
      step();
    end
    check("false_start_len", cnt, 8);
    check("false_start_rdy", rdy, 0);
    check("false_start_data", rx_data, 8'hA5);

    // Break: stop bit low and line held low yields one errored frame.
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 1'b0, -1);
    repeat (100) step();
    check("break_not_recv", receiving, 0);
    check("break_frm_err", frm_err, 1);
    check("break_rdy", rdy, 1);
    RX = 1'b1;
    repeat (4) step();

    // Back-to-back frames; clear on the set edge loses to the set.
    send_frame(8'h00, 1'b1, 1'b0, LAT, LAT + 4, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1, 5, 1'b0, -1);
    check("b2b_data", rx_data, 8'hFF);
    check("b2b_frm_ok", frm_err, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1, -1, 1'b0, -1);
    check("bad_parity", par_err, 1);
    send_frame(8'h07, 1'b1, 1'b0, -1, -1, 1'b0, -1);
    check("good_parity", par_err, 0);
`endif

    // Reset during the 4th data bit, then a clean frame.
    send_frame(8'h96, 1'b1, 1'b0, -1, -1, 1'b0, 70);
    repeat (40) step();
    check("post_rst_no_rdy", rdy, 0);
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1, 1'b0, -1);
    check("post_rst_data", rx_data, 8'h5A);

    repeat (4) step();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
